// File: rtl/key_debounce_if.sv
// Key pin / debounced event bundle between the board-level key pins and key_debounce.
interface key_debounce_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_down;
  logic [N_KEYS-1:0] key_up;
  logic [N_KEYS-1:0] key_long;

  modport master (
    output key_n,
    input  key_level, key_down, key_up, key_long
  );

  modport slave (
    input  key_n,
    output key_level, key_down, key_up, key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-FF synchronizer plus debounce FSM producing a clean level and
// single-cycle press, release and long-press pulses for active-low buttons.
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input logic          clk,
  input logic          rst,
  key_debounce_if.slave kif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LONG_CYCLES) + 1;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] DB_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED    = 2'd2;
  localparam logic [1:0] DB_RELEASE = 2'd3;

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

  // Preset to released so a key held through reset is seen as a fresh press.
  logic [N_KEYS-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= kif.key_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [1:0]    state;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] lcnt;
    logic          fired;
    logic          level, down, up, lng;
    logic          k_s;

    assign k_s = ~sync2[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        dcnt  <= '0;
        lcnt  <= '0;
        fired <= 1'b0;
        level <= 1'b0;
        down  <= 1'b0;
        up    <= 1'b0;
        lng   <= 1'b0;
      end else begin
        down <= 1'b0;
        up   <= 1'b0;
        lng  <= 1'b0;

        // Long count runs through release debounce; saturation blocks retrigger.
        if (state == PRESSED || state == DB_RELEASE) begin
          if (lcnt == L_LAST) begin
            if (!fired) begin
              lng   <= 1'b1;
              fired <= 1'b1;
            end
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end

        case (state)
          IDLE: begin
            if (k_s) begin
              state <= DB_PRESS;
              dcnt  <= DW'(1);
            end
          end
          DB_PRESS: begin
            if (!k_s) begin
              state <= IDLE;
              dcnt  <= '0;
            end else if (dcnt == D_LAST) begin
              state <= PRESSED;
              dcnt  <= '0;
              lcnt  <= '0;
              level <= 1'b1;
              down  <= 1'b1;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          PRESSED: begin
            if (!k_s) begin
              state <= DB_RELEASE;
              dcnt  <= DW'(1);
            end
          end
          DB_RELEASE: begin
            if (k_s) begin
              state <= PRESSED;
              dcnt  <= '0;
            end else if (dcnt == D_LAST) begin
              state <= IDLE;
              dcnt  <= '0;
              level <= 1'b0;
              up    <= 1'b1;
              fired <= 1'b0;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign kif.key_level[i] = level;
    assign kif.key_down[i]  = down;
    assign kif.key_up[i]    = up;
    assign kif.key_long[i]  = lng;
  end

endmodule
